vrf_read_pipe: RTL and testbench

Consumes the single-winner VRF read request stream produced by the VRF read-request arbiter. Issues each accepted request to the VRF SRAM bank and tracks it through the fixed SRAM latency. Returns the read data with its source tags through a small response queue. Credit accounting guarantees the queue never overflows, so backpressure from the response consumer never drops data.

---
 rtl/vrf_read_pkg.sv | 31 +++
 rtl/vrf_read_resp_fifo.sv | 71 +++++++
 rtl/vrf_read_pipe.sv | 135 +++++++++++++
 tb/tb_vrf_read_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vrf_read_pkg.sv
// Shared types, default widths and helpers for the VRF read pipe.
// Pure declarations: no logic, no latency, no flow control.
package vrf_read_pkg;

    localparam int VRF_VS_W         = 5;
    localparam int VRF_OFFSET_W     = 3;
    localparam int VRF_IDX_W        = 3;
    localparam int VRF_SRC_W        = 2;
    localparam int VRF_DATA_W       = 32;
    localparam int VRF_SRAM_LATENCY = 2;
    localparam int VRF_RESP_DEPTH   = 4;

    typedef struct packed {
        logic [VRF_VS_W-1:0]     vs;
        logic [VRF_SRC_W-1:0]    readSource;
        logic [VRF_OFFSET_W-1:0] offset;
        logic [VRF_IDX_W-1:0]    instructionIndex;
    } VRFReadRequest;

    typedef struct packed {
        logic [VRF_DATA_W-1:0] data;
        logic [VRF_SRC_W-1:0]  readSource;
        logic [VRF_IDX_W-1:0]  instructionIndex;
    } VRFReadResponse;

    // Pointer width for a circular buffer; a 1-entry buffer still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/vrf_read_resp_fifo.sv
// Synchronous FIFO with occupancy count; push visible one cycle later, no bypass.
// Backpressure: none internally -- the owner guarantees no push into a full queue without a pop.
module vrf_read_resp_fifo
    import vrf_read_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             full;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign do_pop = pop && !empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Zero when empty so the response fields read as zero while nothing is valid.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

`ifndef SYNTHESIS
    push_into_full: assert property (@(posedge clock) disable iff (!reset)
        !(push && full && !do_pop));
`endif

endmodule

// File: rtl/vrf_read_pipe.sv
// VRF read issue + fixed-latency tag tracking + credited response queue; accept-to-resp_valid is SRAM_LATENCY+1 cycles.
// Backpressure: req_ready drops when in-flight + queued reaches RESP_DEPTH; VRF_READ_PIPE_PERF_EN adds stall counters.
module vrf_read_pipe
    import vrf_read_pkg::*;
#(
    parameter int VS_W         = VRF_VS_W,
    parameter int OFFSET_W     = VRF_OFFSET_W,
    parameter int IDX_W        = VRF_IDX_W,
    parameter int SRC_W        = VRF_SRC_W,
    parameter int DATA_W       = VRF_DATA_W,
    parameter int SRAM_LATENCY = VRF_SRAM_LATENCY,
    parameter int RESP_DEPTH   = VRF_RESP_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [VS_W-1:0]          req_vs,
    input  logic [SRC_W-1:0]         req_readSource,
    input  logic [OFFSET_W-1:0]      req_offset,
    input  logic [IDX_W-1:0]         req_instructionIndex,
    output logic                     sram_en,
    output logic [VS_W+OFFSET_W-1:0] sram_addr,
    input  logic [DATA_W-1:0]        sram_rdata,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic [SRC_W-1:0]         resp_readSource,
    output logic [IDX_W-1:0]         resp_instructionIndex
`ifdef VRF_READ_PIPE_PERF_EN
    ,
    output logic [15:0]              perf_stall_cnt,
    output logic                     perf_resp_stall
`endif
);

    localparam int ADDR_W = VS_W + OFFSET_W;
    localparam int ENT_W  = DATA_W + SRC_W + IDX_W;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 1;

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [CNT_W-1:0]        inflight_count;
    logic [CNT_W-1:0]        queue_count;
    logic [OCC_W-1:0]        occupancy;
    logic [ADDR_W-1:0]       addr_q;
    logic [SRAM_LATENCY-1:0] tag_vld;
    logic [SRC_W-1:0]        tag_src [SRAM_LATENCY];
    logic [IDX_W-1:0]        tag_idx [SRAM_LATENCY];
    logic [ENT_W-1:0]        push_dat;
    logic [ENT_W-1:0]        pop_dat;

    // Credit covers both in-flight reads and queued responses, so the queue cannot overflow.
    assign occupancy = OCC_W'(inflight_count) + OCC_W'(queue_count);
    assign req_ready = reset && (occupancy < OCC_W'(RESP_DEPTH));
    assign accept    = req_valid && req_ready;

    assign sram_en   = accept;
    assign sram_addr = accept ? {req_vs, req_offset} : addr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (accept) begin
            addr_q <= {req_vs, req_offset};
        end
    end

    // Stage k holds tags of a read issued k+1 cycles ago; the last stage lines up with sram_rdata.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            for (int i = 0; i < SRAM_LATENCY; i++) begin
                tag_src[i] <= '0;
                tag_idx[i] <= '0;
            end
        end else begin
            tag_vld[0] <= accept;
            tag_src[0] <= req_readSource;
            tag_idx[0] <= req_instructionIndex;
            for (int i = 1; i < SRAM_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_src[i] <= tag_src[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
        end
    end

    assign push     = tag_vld[SRAM_LATENCY-1];
    assign push_dat = {sram_rdata, tag_src[SRAM_LATENCY-1], tag_idx[SRAM_LATENCY-1]};
    assign pop      = resp_valid && resp_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight_count <= '0;
        end else if (accept && !push) begin
            inflight_count <= inflight_count + CNT_W'(1);
        end else if (!accept && push) begin
            inflight_count <= inflight_count - CNT_W'(1);
        end
    end

    vrf_read_resp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .count    (queue_count)
    );

    assign resp_valid = (queue_count != '0);
    assign {resp_data, resp_readSource, resp_instructionIndex} = pop_dat;

`ifdef VRF_READ_PIPE_PERF_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
        end else if (req_valid && !req_ready && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end

    assign perf_resp_stall = resp_valid && !resp_ready;
`else
    // No performance state in this build.
`endif

endmodule

// File: tb/tb_vrf_read_pipe.sv
// Randomized bench for vrf_read_pipe against a queue-based transaction model and a behavioural SRAM.
module tb_vrf_read_pipe;
    import vrf_read_pkg::*;

    localparam int L     = 2;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_vs = '0;
    logic [1:0]  req_readSource = '0;
    logic [2:0]  req_offset = '0;
    logic [2:0]  req_instructionIndex = '0;
    logic        sram_en;
    logic [7:0]  sram_addr;
    logic [31:0] sram_rdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [1:0]  resp_readSource;
    logic [2:0]  resp_instructionIndex;
`ifdef VRF_READ_PIPE_PERF_EN
    logic [15:0] perf_stall_cnt;
    logic        perf_resp_stall;
`endif

    always #5 clock = ~clock;

    vrf_read_pipe dut (
        .clock                 (clock),
        .reset                 (reset),
        .req_valid             (req_valid),
        .req_ready             (req_ready),
        .req_vs                (req_vs),
        .req_readSource        (req_readSource),
        .req_offset            (req_offset),
        .req_instructionIndex  (req_instructionIndex),
        .sram_en               (sram_en),
        .sram_addr             (sram_addr),
        .sram_rdata            (sram_rdata),
        .resp_valid            (resp_valid),
        .resp_ready            (resp_ready),
        .resp_data             (resp_data),
        .resp_readSource       (resp_readSource),
        .resp_instructionIndex (resp_instructionIndex)
`ifdef VRF_READ_PIPE_PERF_EN
        ,
        .perf_stall_cnt        (perf_stall_cnt),
        .perf_resp_stall       (perf_resp_stall)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Transaction model: expected responses in order, each with the first cycle it may appear.
    VRFReadResponse exp_q[$];
    int             exp_avail[$];
    int             outstanding = 0;
    int             cyc = 0;
    int             acc_cnt = 0;
    int             stall_exp = 0;
    logic [31:0]    mem [256];
    logic           hist_en [int];
    logic [7:0]     hist_addr [int];
    logic [7:0]     last_addr = '0;
    bit             addr_known = 0;
    bit             rst_next = 0;
    bit             last_ready;
    bit             last_rv;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic evaluate();
        bit exp_ready, acc, exp_rv;
        VRFReadResponse r;
        if (!reset) begin
            exp_q.delete();
            exp_avail.delete();
            outstanding = 0;
            addr_known  = 0;
            stall_exp   = 0;
            hist_en[cyc] = 1'b0;
            check_eq("rst_req_ready", req_ready, 0);
            check_eq("rst_sram_en", sram_en, 0);
            check_eq("rst_resp_valid", resp_valid, 0);
            check_eq("rst_resp_data", resp_data, 0);
            check_eq("rst_resp_tags", {resp_readSource, resp_instructionIndex}, 0);
`ifdef VRF_READ_PIPE_PERF_EN
            check_eq("rst_perf_stall_cnt", perf_stall_cnt, 0);
`endif
            last_ready = 0;
            last_rv = 0;
            return;
        end
        exp_ready = (outstanding < DEPTH);
        acc       = req_valid && exp_ready;
        exp_rv    = (exp_q.size() > 0) && (exp_avail[0] <= cyc);
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("sram_en", sram_en, acc);
        if (acc) check_eq("sram_addr", sram_addr, {req_vs, req_offset});
        else if (addr_known) check_eq("sram_addr_hold", sram_addr, last_addr);
        check_eq("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check_eq("resp_data", resp_data, exp_q[0].data);
            check_eq("resp_src", resp_readSource, exp_q[0].readSource);
            check_eq("resp_idx", resp_instructionIndex, exp_q[0].instructionIndex);
        end
`ifdef VRF_READ_PIPE_PERF_EN
        check_eq("perf_stall_cnt", perf_stall_cnt, stall_exp);
        check_eq("perf_resp_stall", perf_resp_stall, exp_rv && !resp_ready);
        if (req_valid && !exp_ready && stall_exp < 65535) stall_exp++;
`endif
        hist_en[cyc]   = sram_en;
        hist_addr[cyc] = sram_addr;
        if (acc) begin
            r.data             = mem[{req_vs, req_offset}];
            r.readSource       = req_readSource;
            r.instructionIndex = req_instructionIndex;
            exp_q.push_back(r);
            exp_avail.push_back(cyc + L + 1);
            outstanding++;
            last_addr  = {req_vs, req_offset};
            addr_known = 1;
            acc_cnt++;
        end
        if (exp_rv && resp_ready) begin
            void'(exp_q.pop_front());
            void'(exp_avail.pop_front());
            outstanding--;
        end
        last_ready = req_ready;
        last_rv    = resp_valid;
    endtask

    task automatic step(input logic v, input logic [4:0] vs, input logic [2:0] off,
                        input logic [1:0] src, input logic [2:0] idx, input logic rr);
        @(posedge clock);
        #1;
        cyc++;
        reset                = rst_next;
        req_valid            = v;
        req_vs               = vs;
        req_offset           = off;
        req_readSource       = src;
        req_instructionIndex = idx;
        resp_ready           = rr;
        if (hist_en.exists(cyc - L) && hist_en[cyc - L]) sram_rdata = mem[hist_addr[cyc - L]];
        else sram_rdata = $urandom;
        @(negedge clock);
        evaluate();
    endtask

    task automatic rand_step(input logic v, input logic rr);
        step(v, 5'($urandom), 3'($urandom), 2'($urandom), 3'($urandom), rr);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) rand_step(0, 1);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h2B] = 32'hDEADBEEF;

        // Reset held for a few cycles.
        rst_next = 0;
        for (int i = 0; i < 3; i++) rand_step(1, 1);
        rst_next = 1;

        // Directed single request: vs=5, offset=3 -> row 0x2B.
        step(1, 5'd5, 3'd3, 2'd2, 3'd1, 1);
        check_eq("t1_addr", sram_addr, 8'h2B);
        rand_step(0, 1);
        rand_step(0, 1);
        check_eq("t1_not_yet", resp_valid, 0);
        rand_step(0, 1);
        check_eq("t1_valid", resp_valid, 1);
        check_eq("t1_data", resp_data, 32'hDEADBEEF);
        check_eq("t1_tags", {resp_readSource, resp_instructionIndex}, {2'd2, 3'd1});
        drain();

        // Eight back-to-back reads with the consumer always ready.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) rand_step(1, 1);
        check_eq("b2b_accepts", acc_cnt, 8);
        drain();

        // Stalled consumer: credit allows exactly DEPTH accepts.
        acc_cnt = 0;
        for (int i = 0; i < 8; i++) rand_step(1, 0);
        check_eq("bp_accepts", acc_cnt, DEPTH);
        rand_step(1, 1);
        check_eq("bp_pop_same_cycle_ready", last_ready, 0);
        rand_step(1, 0);
        check_eq("bp_ready_next_cycle", last_ready, 1);
        rand_step(0, 0);
        rand_step(0, 1);
        rand_step(0, 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) rand_step(($urandom % 4) != 0, ($urandom % 3) != 0);
        drain();

        // Reset with two reads in flight; stale SRAM returns must be dropped.
        rand_step(1, 1);
        rand_step(1, 1);
        rst_next = 0;
        rand_step(0, 1);
        check_eq("midrst_resp_valid", last_rv, 0);
        rand_step(0, 1);
        rst_next = 1;
        rand_step(0, 1);
        check_eq("midrst_ready_first", last_ready, 1);
        for (int i = 0; i < 5; i++) rand_step(0, 1);
        rand_step(1, 1);
        drain();

`ifdef VRF_READ_PIPE_PERF_EN
        for (int i = 0; i < 20; i++) rand_step(1, 0);
        rand_step(0, 0);
        check_eq("perf_stall_16", perf_stall_cnt, 16);
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
